// File: rtl/fp_mult_pack.sv
// fp_mult_pack: final stage of the FP multiplier. Normalizes the fraction product, rounds to
// nearest-even, resolves overflow/underflow/special values and packs the result word.
// Two-stage valid/ready pipeline. Define FP_MULT_PACK_FLAGS_EN to add the IEEE status flags
// output {invalid, overflow, underflow, inexact}.

`ifndef FP16
`define FP16 1
`endif
`ifndef FP32
`define FP32 0
`endif
`ifndef FP64
`define FP64 2
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN ((data_format == `FP16) ? 5 : (data_format == `FP64) ? 11 : 8)
`endif
`ifndef GET_MANTISSA_LEN
`define GET_MANTISSA_LEN ((data_format == `FP16) ? 10 : (data_format == `FP64) ? 52 : 23)
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN ((data_format == `FP16) ? 16 : (data_format == `FP64) ? 64 : 32)
`endif

module fp_mult_pack #(
    parameter int unsigned data_format = `FP32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              sign,
    input  logic [`GET_EXP_LEN-1:0]           a_exp,
    input  logic [`GET_EXP_LEN-1:0]           b_exp,
    input  logic [2*`GET_MANTISSA_LEN+1:0]    prod,
    input  logic                              a_zero,
    input  logic                              b_zero,
    input  logic                              a_inf,
    input  logic                              b_inf,
    input  logic                              a_nan,
    input  logic                              b_nan,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [`GET_FP_LEN-1:0]            result
`ifdef FP_MULT_PACK_FLAGS_EN
    ,
    output logic [3:0]                        flags
`endif
);

    localparam int unsigned E = `GET_EXP_LEN;
    localparam int unsigned M = `GET_MANTISSA_LEN;
    localparam int unsigned W = `GET_FP_LEN;

    // Exponent arithmetic is done in E+2 bits so the signed intermediate never wraps.
    localparam logic [E+1:0] BIAS_X  = {3'b000, {(E-1){1'b1}}};
    localparam logic [E+1:0] EXP_MAX = {2'b00, {E{1'b1}}};

    typedef enum logic [1:0] {ClsNormal, ClsZero, ClsInf, ClsNan} cls_e;

    logic           s2_ready;
    logic           nrm;
    logic           zero_inf;
    logic [M-1:0]   mant_c;
    logic           guard_c;
    logic           sticky_c;
    logic [E+1:0]   exp_c;
    cls_e           cls_c;

    logic           s1_valid;
    logic           s1_sign;
    logic [M-1:0]   s1_mant;
    logic           s1_guard;
    logic           s1_sticky;
    logic [E+1:0]   s1_exp;
    cls_e           s1_cls;

    logic           inc;
    logic [M:0]     mant_sum;
    logic [E+1:0]   exp_f;
    logic           ovf;
    logic           unf;
    logic [W-1:0]   result_d;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign zero_inf = (a_zero & b_inf) | (a_inf & b_zero);

    // Normalize the product, form the unrounded exponent and classify the operands.
    always_comb begin
        nrm      = prod[2*M+1];
        mant_c   = nrm ? prod[2*M -: M] : prod[2*M-1 -: M];
        guard_c  = nrm ? prod[M] : prod[M-1];
        sticky_c = nrm ? |prod[M-1:0] : |prod[M-2:0];
        exp_c    = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_X + {{(E+1){1'b0}}, nrm};
        cls_c    = ClsNormal;
        if (a_nan || b_nan || zero_inf) begin
            cls_c = ClsNan;
        end else if (a_inf || b_inf) begin
            cls_c = ClsInf;
        end else if (a_zero || b_zero) begin
            cls_c = ClsZero;
        end
    end

`ifdef FP_MULT_PACK_FLAGS_EN
    logic       s1_invalid;
    logic [3:0] flags_d;
`endif

    // Stage 1 register: loads whenever it is empty or its content moves to stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_mant   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
            s1_cls    <= ClsNormal;
`ifdef FP_MULT_PACK_FLAGS_EN
            s1_invalid <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= sign;
                s1_mant   <= mant_c;
                s1_guard  <= guard_c;
                s1_sticky <= sticky_c;
                s1_exp    <= exp_c;
                s1_cls    <= cls_c;
`ifdef FP_MULT_PACK_FLAGS_EN
                // NaN operands propagate quietly; only 0*inf raises invalid.
                s1_invalid <= zero_inf && !(a_nan || b_nan);
`endif
            end
        end
    end

    // Round to nearest-even, then resolve specials, overflow and underflow in priority order.
    always_comb begin
        inc      = s1_guard & (s1_sticky | s1_mant[0]);
        mant_sum = {1'b0, s1_mant} + {{M{1'b0}}, inc};
        // A carry out of the mantissa leaves the fraction field zero and bumps the exponent.
        exp_f    = s1_exp + {{(E+1){1'b0}}, mant_sum[M]};
        ovf      = !exp_f[E+1] && (exp_f >= EXP_MAX);
        unf      = exp_f[E+1] || (exp_f == '0);
        result_d = '0;
        case (s1_cls)
            ClsNan:  result_d = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            ClsInf:  result_d = {s1_sign, {E{1'b1}}, {M{1'b0}}};
            ClsZero: result_d = {s1_sign, {(W-1){1'b0}}};
            default: begin
                if (ovf) begin
                    result_d = {s1_sign, {E{1'b1}}, {M{1'b0}}};
                end else if (unf) begin
                    result_d = {s1_sign, {(W-1){1'b0}}};
                end else begin
                    result_d = {s1_sign, exp_f[E-1:0], mant_sum[M-1:0]};
                end
            end
        endcase
    end

`ifdef FP_MULT_PACK_FLAGS_EN
    // Status flags for the beat currently in stage 1.
    always_comb begin
        flags_d = '0;
        if (s1_cls == ClsNan) begin
            flags_d[3] = s1_invalid;
        end else if (s1_cls == ClsNormal) begin
            flags_d[2] = ovf;
            flags_d[1] = !ovf && unf;
            flags_d[0] = s1_guard || s1_sticky || ovf || unf;
        end
    end
`endif

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
`ifdef FP_MULT_PACK_FLAGS_EN
            flags     <= '0;
`endif
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= result_d;
`ifdef FP_MULT_PACK_FLAGS_EN
                flags  <= flags_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pack.sv
// Bench for fp_mult_pack (FP32): directed corner beats with hand-derived results, a
// backpressure scenario, mid-stream reset and a random stream against an arithmetic model.
module tb_fp_mult_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [47:0] prod;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FP_MULT_PACK_FLAGS_EN
    logic [3:0]  flags;
`endif

    always #5 clk = ~clk;

    fp_mult_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .prod      (prod),
        .a_zero    (a_zero),
        .b_zero    (b_zero),
        .a_inf     (a_inf),
        .b_inf     (b_inf),
        .a_nan     (a_nan),
        .b_nan     (b_nan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FP_MULT_PACK_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    typedef struct {
        logic        sign;
        logic [7:0]  a_exp;
        logic [7:0]  b_exp;
        logic [47:0] prod;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    } beat_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Result and flags for one beat, from the rounding rules applied to the exact product.
    function automatic logic [35:0] model(input beat_t b);
        logic [3:0]      f;
        logic [31:0]     r;
        longint unsigned p, q, rem, half;
        int              sh, e;
        logic            zi, nan;
        zi  = (b.a_zero && b.b_inf) || (b.a_inf && b.b_zero);
        nan = b.a_nan || b.b_nan || zi;
        f   = 4'b0000;
        if (nan) begin
            r    = 32'h7FC00000;
            f[3] = zi && !(b.a_nan || b.b_nan);
        end else if (b.a_inf || b.b_inf) begin
            r = {b.sign, 31'h7F800000};
        end else if (b.a_zero || b.b_zero) begin
            r = {b.sign, 31'h0};
        end else begin
            p  = 64'(b.prod);
            e  = int'(b.a_exp) + int'(b.b_exp) - 127;
            sh = 23;
            if (p >= 64'h8000_0000_0000) begin
                sh = 24;
                e++;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                e++;
            end
            f[0] = (rem != 0);
            if (e >= 255) begin
                r    = {b.sign, 31'h7F800000};
                f[2] = 1'b1;
                f[0] = 1'b1;
            end else if (e <= 0) begin
                r    = {b.sign, 31'h0};
                f[1] = 1'b1;
                f[0] = 1'b1;
            end else begin
                r = {b.sign, e[7:0], q[22:0]};
            end
        end
        return {f, r};
    endfunction

    function automatic beat_t mk(input logic s, input logic [7:0] ae, input logic [7:0] be,
                                 input logic [47:0] p);
        beat_t b;
        b.sign = s; b.a_exp = ae; b.b_exp = be; b.prod = p;
        b.a_zero = 0; b.b_zero = 0; b.a_inf = 0; b.b_inf = 0; b.a_nan = 0; b.b_nan = 0;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [23:0] fa, fb;
        fa = {1'b1, 23'($urandom)};
        fb = {1'b1, 23'($urandom)};
        b  = mk(1'($urandom), 8'($urandom), 8'($urandom), 48'(fa) * 48'(fb));
        if ($urandom_range(0, 7) == 0) begin
            b.a_zero = 1'($urandom); b.b_zero = 1'($urandom);
            b.a_inf  = 1'($urandom); b.b_inf  = 1'($urandom);
            b.a_nan  = ($urandom_range(0, 3) == 0);
            b.b_nan  = ($urandom_range(0, 3) == 0);
        end
        return b;
    endfunction

    task automatic drive(input beat_t b);
        sign = b.sign; a_exp = b.a_exp; b_exp = b.b_exp; prod = b.prod;
        a_zero = b.a_zero; b_zero = b.b_zero; a_inf = b.a_inf; b_inf = b.b_inf;
        a_nan = b.a_nan; b_nan = b.b_nan;
    endtask

    task automatic check_out(input string tag, input logic [35:0] want);
        check({tag, "_res"}, 64'(result), 64'(want[31:0]));
`ifdef FP_MULT_PACK_FLAGS_EN
        check({tag, "_flags"}, 64'(flags), 64'(want[35:32]));
`endif
    endtask

    // Single beat into an empty pipe: checks the 2-cycle latency and the packed value.
    task automatic run_one(input string tag, input beat_t b, input logic [31:0] want_res,
                           input logic [3:0] want_flags);
        drive(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_lat2"}, 64'(out_valid), 64'd1);
        check_out(tag, {want_flags, want_res});
        @(negedge clk);
    endtask

    // Stream of random beats. mode 1: consumer stalled for cycles 0-4, then always ready.
    task automatic run_stream(input string tag, input int n_beats, input int mode,
                              input int max_cycles);
        beat_t       sendq[$];
        logic [35:0] expq[$];
        logic [31:0] prev_res;
        logic        prev_stall;
        int          acc;
        int          cyc;
        for (int i = 0; i < n_beats; i++) sendq.push_back(rand_beat());
        prev_stall = 1'b0;
        prev_res   = '0;
        acc        = 0;
        cyc        = 0;
        while (cyc < max_cycles && (sendq.size() > 0 || expq.size() > 0 || out_valid)) begin
            in_valid = (sendq.size() > 0);
            if (in_valid) drive(sendq[0]);
            out_ready = (mode == 1) ? (cyc >= 5) : ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_hold_res"}, 64'(result), 64'(prev_res));
            end
            if (mode == 1 && cyc == 2) begin
                check({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
                check({tag, "_bp_accepts"}, 64'(acc), 64'd2);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) check({tag, "_extra"}, 64'(out_valid), 64'd0);
                else check_out(tag, expq.pop_front());
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(sendq.pop_front()));
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_drained"}, 64'(sendq.size() + expq.size()), 64'd0);
        check({tag, "_delivered"}, 64'(acc), 64'(n_beats));
    endtask

    initial begin
        beat_t b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(mk(0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_one("three", mk(0, 127, 128, 48'h600000000000), 32'h40400000, 4'b0000);
        run_one("tie_odd", mk(0, 127, 127, 48'h600000C00000), 32'h3FC00002, 4'b0001);
        run_one("below_half", mk(0, 127, 127, 48'h400001000001), 32'h3F800002, 4'b0001);
        run_one("carry", mk(0, 127, 127, 48'hFFFFFF800000), 32'h40800000, 4'b0001);
        run_one("ovf", mk(1, 254, 254, 48'h400000000000), 32'hFF800000, 4'b0101);
        run_one("unf", mk(0, 1, 1, 48'h400000000000), 32'h00000000, 4'b0011);
        b = mk(0, 0, 255, 48'h0); b.a_zero = 1; b.b_inf = 1;
        run_one("zero_x_inf", b, 32'h7FC00000, 4'b1000);
        b = mk(1, 255, 130, 48'h400000000000); b.a_nan = 1;
        run_one("nan_in", b, 32'h7FC00000, 4'b0000);
        b = mk(1, 255, 130, 48'h400000000000); b.a_inf = 1;
        run_one("inf_in", b, 32'hFF800000, 4'b0000);
        b = mk(1, 130, 0, 48'h0); b.b_zero = 1;
        run_one("zero_in", b, 32'h80000000, 4'b0000);

        run_stream("bp", 4, 1, 40);

        // Fill both stages, then reset for one cycle: everything in flight is dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(mk(0, 127, 128, 48'h600000000000));
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        check("midrst_no_replay", 64'(out_valid), 64'd0);
        @(negedge clk);

        run_stream("rand", 300, 0, 3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
